// File: rtl/chinx_fetch_queue.sv
// Instruction-fetch front end: one outstanding memory request feeding a DEPTH-entry {pc, instr} queue toward decode.
// Redirect to first valid_o takes 3 cycles with a 1-cycle memory; issue stalls while the queue is full or a fetch is in flight.
module chinx_fetch_queue #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    DEPTH       = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             bsrc_i,
   input  logic [ADDR_WIDTH-1:0]  baddr_i,
   input  logic [ADDR_WIDTH-1:0]  epc_i,
   input  logic [ADDR_WIDTH-1:0]  ipc_i,
   input  logic [ADDR_WIDTH-1:0]  rpc_i,
   output logic                   imem_req_o,
   output logic [ADDR_WIDTH-1:0]  imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   output logic [INSTR_WIDTH-1:0] instr_o
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
   } entry_t;

   entry_t                q_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [PTR_W:0]        count;
   logic [ADDR_WIDTH-1:0] fpc, req_pc, target;
   logic                  outstanding, discard;
   logic                  redirect, full, issue, rsp, push, pop;

   always_comb begin
      redirect = (bsrc_i != 3'd0);
      unique case (bsrc_i)
         3'd2:    target = epc_i;
         3'd3:    target = ipc_i;
         3'd4:    target = rpc_i;
         default: target = baddr_i;
      endcase
      full        = (count == (PTR_W+1)'(DEPTH));
      // Gated by rst so no request escapes while the core is held in reset.
      imem_req_o  = !rst && !redirect && !outstanding && !full;
      imem_addr_o = fpc;
      issue       = imem_req_o && imem_gnt_i;
      rsp         = imem_rvalid_i && outstanding;
      push        = rsp && !discard && !redirect;
      valid_o     = (count != '0);
      pop         = valid_o && ready_i && !redirect;
      pc_o        = q_mem[rd_ptr].pc;
      instr_o     = q_mem[rd_ptr].instr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc         <= RESET_PC;
         req_pc      <= '0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
      end else if (redirect) begin
         fpc <= target;
         // A response landing in the redirect cycle retires the fetch; otherwise mark it stale.
         if (outstanding) begin
            if (imem_rvalid_i) begin
               outstanding <= 1'b0;
               discard     <= 1'b0;
            end else begin
               discard     <= 1'b1;
            end
         end
      end else begin
         if (issue) begin
            req_pc      <= fpc;
            fpc         <= fpc + PC_STEP;
            outstanding <= 1'b1;
         end
         if (rsp) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q_mem[wr_ptr] <= '{pc: req_pc, instr: imem_rdata_i};
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);
      end
   end

endmodule

// File: tb/tb_chinx_fetch_queue.sv
// Bench for chinx_fetch_queue: random-latency memory responder, redirect-driven expected PC stream, negedge monitor.
module tb_chinx_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  bsrc_i;
   logic [31:0] baddr_i, epc_i, ipc_i, rpc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i, imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        valid_o, ready_i;
   logic [31:0] pc_o, instr_o;

   int checks = 0;
   int errors = 0;
   int lat = 1;
   int gnt_pct = 100;
   int pops = 0;
   logic [31:0] exp_q[$];

   chinx_fetch_queue dut (
      .clk(clk), .rst(rst), .bsrc_i(bsrc_i), .baddr_i(baddr_i), .epc_i(epc_i),
      .ipc_i(ipc_i), .rpc_i(rpc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] redirect_target(logic [2:0] b, logic [31:0] ba,
                                                   logic [31:0] e, logic [31:0] i, logic [31:0] r);
      case (b)
         3'd2:    return e;
         3'd3:    return i;
         3'd4:    return r;
         default: return ba;
      endcase
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every redirect (and reset) restarts the architectural stream at its target.
   task automatic restart_stream(logic [31:0] t);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(t + 32'(i));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(logic [2:0] b, logic [31:0] v);
      bsrc_i = b;
      case (b)
         3'd2:    epc_i   = v;
         3'd3:    ipc_i   = v;
         3'd4:    rpc_i   = v;
         default: baddr_i = v;
      endcase
      restart_stream(v);
      step();
      bsrc_i = 3'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      restart_stream(32'h0);
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(string name, logic use_addr, logic [31:0] addr);
      bit found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         if (imem_req_o && imem_gnt_i && (!use_addr || imem_addr_o == addr)) found = 1;
      end
      check(name, 64'(found), 64'd1);
   endtask

   task automatic wait_valid_pc(string name, logic [31:0] pc);
      bit found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         if (valid_o) begin
            found = 1;
            check(name, 64'(pc_o), 64'(pc));
         end
      end
      if (!found) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   // Memory model: grant seen in cycle G returns data in cycle G+lat.
   initial begin
      bit          pend = 0;
      int          left = 0;
      logic [31:0] paddr = '0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      forever begin
         @(posedge clk);
         #1;
         imem_rvalid_i = 1'b0;
         if (rst) pend = 0;
         if (pend) begin
            left--;
            if (left == 0) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = mem_word(paddr);
               pend = 0;
            end
         end
         imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
         @(negedge clk);
         if (rst) pend = 0;
         else if (imem_req_o && imem_gnt_i) begin
            pend = 1; left = lat; paddr = imem_addr_o;
         end
      end
   end

   // Monitor: compares every accepted head entry and checks hold stability under backpressure.
   initial begin
      bit          hold = 0;
      logic [31:0] hpc = '0, hinstr = '0;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 0;
         end else begin
            if (hold) begin
               check("hold_valid", 64'(valid_o), 64'd1);
               check("hold_pc", 64'(pc_o), 64'(hpc));
               check("hold_instr", 64'(instr_o), 64'(hinstr));
            end
            if (valid_o && ready_i && bsrc_i == 3'd0) begin
               if (exp_q.size() == 0) begin
                  check("sb_empty", 64'(pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_pc", 64'(pc_o), 64'(e));
                  check("sb_instr", 64'(instr_o), 64'(mem_word(e)));
                  pops++;
                  while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd1);
               end
            end
            hold   = valid_o && !ready_i && bsrc_i == 3'd0;
            hpc    = pc_o;
            hinstr = instr_o;
         end
      end
   end

   initial begin
      int seen, last, first, rnd_pops;
      rst = 1'b1; bsrc_i = '0; baddr_i = '0; epc_i = '0; ipc_i = '0; rpc_i = '0; ready_i = 1'b1;
      restart_stream(32'h0);
      step();
      step();
      check("rst_req", 64'(imem_req_o), 64'd0);
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_pc", 64'(pc_o), 64'd0);
      check("rst_instr", 64'(instr_o), 64'd0);
      rst = 1'b0;

      // Back-to-back stream from reset: one instruction every two cycles.
      seen = 0; last = -1; first = -1;
      for (int c = 0; c < 20 && seen < 4; c++) begin
         @(negedge clk);
         if (valid_o) begin
            if (seen == 0) first = c;
            else check("t1_gap", 64'(c - last), 64'd2);
            last = c;
            seen++;
         end
      end
      check("t1_first_cycle", 64'(first), 64'd2);
      check("t1_count", 64'(seen), 64'd4);
      step();

      // Backpressure: queue fills, issue stops, head holds pc 0.
      ready_i = 1'b0;
      do_reset();
      repeat (20) step();
      @(negedge clk);
      check("t2_req_blocked", 64'(imem_req_o), 64'd0);
      check("t2_valid", 64'(valid_o), 64'd1);
      check("t2_head_pc", 64'(pc_o), 64'd0);
      step();
      ready_i = 1'b1;
      repeat (4) wait_valid_pc("t2_drain", exp_q[0]);
      check("t2_resume_next", 64'(exp_q[0]), 64'd4);
      wait_valid_pc("t2_resume", 32'd4);
      step();

      // Redirect while pc 5 is in flight: its response must be dropped.
      do_reset();
      lat = 3;
      wait_grant("t3_grant_pc5", 1'b1, 32'd5);
      step();
      redirect(3'd1, 32'h40);
      wait_valid_pc("t3_first", 32'h40);
      step();

      // Redirect coinciding with a response and a pop.
      lat = 1;
      ready_i = 1'b0;
      repeat (6) step();
      ready_i = 1'b1;
      wait_grant("t4_grant", 1'b0, 32'h0);
      step();
      bsrc_i = 3'd3; ipc_i = 32'h100;
      restart_stream(32'h100);
      @(negedge clk);
      check("t4_coincide", 64'({imem_rvalid_i, valid_o, ready_i}), 64'b111);
      step();
      bsrc_i = 3'd0;
      @(negedge clk);
      check("t4_flushed", 64'(valid_o), 64'd0);
      wait_valid_pc("t4_ipc", 32'h100);
      step();
      redirect(3'd4, 32'h23);
      wait_valid_pc("t4_rpc", 32'h23);
      step();

      // Redirect-to-valid latency and address wrap.
      redirect(3'd1, 32'hFFFF_FFFF);
      @(negedge clk);
      check("t5_lat_n1", 64'(valid_o), 64'd0);
      @(negedge clk);
      check("t5_lat_n2", 64'(valid_o), 64'd0);
      @(negedge clk);
      check("t5_lat_n3", 64'({valid_o, pc_o}), {31'd0, 1'b1, 32'hFFFF_FFFF});
      wait_valid_pc("t5_wrap", 32'h0);

      // Asynchronous reset in the middle of an outstanding fetch.
      lat = 3;
      wait_grant("t5_grant", 1'b0, 32'h0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      restart_stream(32'h0);
      #1;
      check("t5_arst_req", 64'(imem_req_o), 64'd0);
      check("t5_arst_valid", 64'(valid_o), 64'd0);
      check("t5_arst_pc", 64'(pc_o), 64'd0);
      check("t5_arst_instr", 64'(instr_o), 64'd0);
      step();
      step();
      rst = 1'b0;
      wait_valid_pc("t5_restart", 32'h0);
      step();

      // Random traffic against the redirect-stream model.
      gnt_pct = 60;
      rnd_pops = pops;
      for (int c = 0; c < 3000; c++) begin
         lat     = $urandom_range(1, 3);
         ready_i = ($urandom_range(0, 9) < 7);
         baddr_i = $urandom; epc_i = $urandom; ipc_i = $urandom; rpc_i = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            bsrc_i = 3'($urandom_range(1, 7));
            restart_stream(redirect_target(bsrc_i, baddr_i, epc_i, ipc_i, rpc_i));
         end else begin
            bsrc_i = 3'd0;
         end
         step();
      end
      bsrc_i = 3'd0;
      ready_i = 1'b1;
      repeat (50) step();
      check("rnd_progress", 64'(pops - rnd_pops > 100), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
